ghost_sprite_renderer: RTL and testbench

- Consumer stage for the 26x26 ghost sprite RAM (24-bit RGB words, 676 entries, registered read, 1-cycle latency).
- Converts the VGA beam position (DrawX/DrawY) into a sprite read address, aligns the RAM output with the beam pipeline, and applies transparency.
- Applies the frightened/flash colour override and emits a per-pixel hit flag plus RGB to the colour mapper.
- Ghost position is latched once per frame so the sprite never tears mid-frame.

---
 rtl/ghost_sprite_renderer_if.sv | 31 +++
 rtl/ghost_sprite_renderer.sv | 159 +++++++++++++++
 tb/tb_ghost_sprite_renderer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ghost_sprite_renderer_if.sv
// Beam, sprite-RAM and pixel signals between the ghost renderer and its surroundings.
// Free-running stream: there is no valid/ready; every clock is one pixel beat, and results appear exactly two clocks later.
interface ghost_sprite_renderer_if;
  logic        VS;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [9:0]  ghost_x;
  logic [9:0]  ghost_y;
  logic        fright_start;
  logic        ghost_eaten;
  logic [9:0]  read_address;
  logic [23:0] ram_data;
  logic        pixel_on;
  logic [23:0] pixel_rgb;
  logic        frightened;
  logic [1:0]  dbg_state;
  logic [8:0]  dbg_frame_cnt;
  logic        dbg_flash_phase;

  modport master (
    output VS, DrawX, DrawY, ghost_x, ghost_y, fright_start, ghost_eaten, ram_data,
    input  read_address, pixel_on, pixel_rgb, frightened,
    input  dbg_state, dbg_frame_cnt, dbg_flash_phase
  );

  modport slave (
    input  VS, DrawX, DrawY, ghost_x, ghost_y, fright_start, ghost_eaten, ram_data,
    output read_address, pixel_on, pixel_rgb, frightened,
    output dbg_state, dbg_frame_cnt, dbg_flash_phase
  );
endinterface

// File: rtl/ghost_sprite_renderer.sv
// Ghost sprite renderer: beam hit test, sprite RAM addressing, 2-stage colour pipeline
// and the NORMAL/FRIGHT/FLASH colour state machine.
module ghost_sprite_renderer #(
  parameter int          SPR_W         = 26,
  parameter int          SPR_H         = 26,
  parameter logic [23:0] TRANSPARENT   = 24'h000000,
  parameter int          FRIGHT_FRAMES = 360,
  parameter int          FLASH_FRAMES  = 120,
  parameter int          FLASH_HALF    = 8
) (
  input logic Clk,
  input logic Reset_n,
  ghost_sprite_renderer_if.slave bus
);
  localparam logic [1:0]  ST_NORMAL   = 2'd0;
  localparam logic [1:0]  ST_FRIGHT   = 2'd1;
  localparam logic [1:0]  ST_FLASH    = 2'd2;
  localparam logic [8:0]  FRIGHT_LAST = 9'(FRIGHT_FRAMES - 1);
  localparam logic [8:0]  FLASH_LAST  = 9'(FLASH_FRAMES - 1);
  localparam logic [8:0]  HALF_LAST   = 9'(FLASH_HALF - 1);
  localparam logic [10:0] W11         = 11'(SPR_W);
  localparam logic [10:0] H11         = 11'(SPR_H);
  localparam logic [9:0]  W10         = 10'(SPR_W);
  localparam logic [23:0] WHITE       = 24'hFFFFFF;

  logic [9:0]  pos_x, pos_y;
  logic        vs_d, frame_tick;
  logic        hit, hit_d1;
  logic [9:0]  dx, dy;
  logic [1:0]  state, state_n;
  logic [8:0]  frame_cnt, cnt_n;
  logic [8:0]  half_cnt, half_n;
  logic        flash_phase, phase_n;
  logic        frightened;
  logic        pixel_on;
  logic [23:0] pixel_rgb;
  logic [23:0] recol;
  logic        visible;

  assign frame_tick = vs_d & ~bus.VS;

  // Bounds use 11 bits so a ghost parked near column 1023 cannot wrap onto column 0.
  assign hit = ({1'b0, bus.DrawX} >= {1'b0, pos_x}) && ({1'b0, bus.DrawX} < ({1'b0, pos_x} + W11)) &&
               ({1'b0, bus.DrawY} >= {1'b0, pos_y}) && ({1'b0, bus.DrawY} < ({1'b0, pos_y} + H11));
  assign dx  = bus.DrawX - pos_x;
  assign dy  = bus.DrawY - pos_y;
  assign bus.read_address = hit ? (dy * W10 + dx) : 10'd0;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pos_x  <= '0;
      pos_y  <= '0;
      vs_d   <= 1'b1;
      hit_d1 <= 1'b0;
    end else begin
      vs_d   <= bus.VS;
      hit_d1 <= hit;
      if (frame_tick) begin
        pos_x <= bus.ghost_x;
        pos_y <= bus.ghost_y;
      end
    end
  end

  // ghost_eaten outranks fright_start; either one discards any pending frame tick.
  always_comb begin
    state_n = state;
    cnt_n   = frame_cnt;
    half_n  = half_cnt;
    phase_n = flash_phase;
    if (bus.ghost_eaten) begin
      state_n = ST_NORMAL;
      cnt_n   = '0;
      half_n  = '0;
      phase_n = 1'b0;
    end else if (bus.fright_start) begin
      state_n = ST_FRIGHT;
      cnt_n   = '0;
      half_n  = '0;
      phase_n = 1'b0;
    end else if (frame_tick) begin
      case (state)
        ST_FRIGHT: begin
          if (frame_cnt == FRIGHT_LAST) begin
            state_n = ST_FLASH;
            cnt_n   = '0;
            half_n  = '0;
            phase_n = 1'b0;
          end else begin
            cnt_n = frame_cnt + 9'd1;
          end
        end
        ST_FLASH: begin
          if (frame_cnt == FLASH_LAST) begin
            state_n = ST_NORMAL;
            cnt_n   = '0;
            half_n  = '0;
            phase_n = 1'b0;
          end else begin
            cnt_n = frame_cnt + 9'd1;
            if (half_cnt == HALF_LAST) begin
              half_n  = '0;
              phase_n = ~flash_phase;
            end else begin
              half_n = half_cnt + 9'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= ST_NORMAL;
      frame_cnt   <= '0;
      half_cnt    <= '0;
      flash_phase <= 1'b0;
      frightened  <= 1'b0;
    end else begin
      state       <= state_n;
      frame_cnt   <= cnt_n;
      half_cnt    <= half_n;
      flash_phase <= phase_n;
      frightened  <= (state_n != ST_NORMAL);
    end
  end

  always_comb begin
    case (state)
      ST_FRIGHT: recol = (bus.ram_data == WHITE) ? 24'hFFB8AE : 24'h2121DE;
      ST_FLASH: begin
        if (flash_phase) recol = (bus.ram_data == WHITE) ? 24'hFF0000 : 24'hFFFFFF;
        else             recol = (bus.ram_data == WHITE) ? 24'hFFB8AE : 24'h2121DE;
      end
      default:   recol = bus.ram_data;
    endcase
  end

  assign visible = hit_d1 && (bus.ram_data != TRANSPARENT);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pixel_on  <= 1'b0;
      pixel_rgb <= '0;
    end else begin
      pixel_on  <= visible;
      pixel_rgb <= visible ? recol : 24'h000000;
    end
  end

  assign bus.pixel_on        = pixel_on;
  assign bus.pixel_rgb       = pixel_rgb;
  assign bus.frightened      = frightened;
  assign bus.dbg_state       = state;
  assign bus.dbg_frame_cnt   = frame_cnt;
  assign bus.dbg_flash_phase = flash_phase;
endmodule

// File: tb/tb_ghost_sprite_renderer.sv
// Directed bench for ghost_sprite_renderer: sprite RAM model, pixel scoreboard and fright timeline.
module tb_ghost_sprite_renderer;
  logic clk = 1'b0;
  logic Reset_n;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   px = 0;
  int   py = 0;
  int   mdl_mode = 0;
  int   mdl_phase = 0;
  logic [23:0] mem [0:1023];
  logic [40:0] exp_q[$];

  ghost_sprite_renderer_if bus ();

  ghost_sprite_renderer #(
    .FRIGHT_FRAMES(4),
    .FLASH_FRAMES (4),
    .FLASH_HALF   (2)
  ) dut (
    .Clk    (clk),
    .Reset_n(Reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.ram_data <= mem[bus.read_address];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_hit(input int x, input int y);
    return (x >= px) && (x < px + 26) && (y >= py) && (y < py + 26);
  endfunction

  function automatic int model_addr(input int x, input int y);
    return model_hit(x, y) ? (y - py) * 26 + (x - px) : 0;
  endfunction

  function automatic logic [23:0] model_color(input logic [23:0] c);
    if (mdl_mode == 0) return c;
    if (mdl_mode == 2 && mdl_phase == 1) return (c == 24'hFFFFFF) ? 24'hFF0000 : 24'hFFFFFF;
    return (c == 24'hFFFFFF) ? 24'hFFB8AE : 24'h2121DE;
  endfunction

  task automatic check_due();
    logic [40:0] e;
    while (exp_q.size() > 0 && exp_q[0][40:25] == 16'(cyc)) begin
      e = exp_q.pop_front();
      chk("pix_on", {31'd0, bus.pixel_on}, {31'd0, e[24]});
      chk("pix_rgb", {8'd0, bus.pixel_rgb}, {8'd0, e[23:0]});
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_due();
  endtask

  task automatic drive_pix(input int x, input int y);
    int a;
    logic on;
    logic [23:0] rgb;
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    a = model_addr(x, y);
    #1;
    chk("addr", {22'd0, bus.read_address}, a);
    on  = model_hit(x, y) && (mem[a] != 24'h000000);
    rgb = on ? model_color(mem[a]) : 24'h000000;
    exp_q.push_back({16'(cyc + 2), on, rgb});
    tick_clk();
  endtask

  task automatic drain();
    repeat (3) tick_clk();
    chk("sb_drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic frame_tick();
    bus.VS = 1'b0;
    tick_clk();
    bus.VS = 1'b1;
    px = bus.ghost_x;
    py = bus.ghost_y;
    tick_clk();
  endtask

  task automatic pulse(input bit fs, input bit ge);
    bus.fright_start = fs;
    bus.ghost_eaten  = ge;
    tick_clk();
    bus.fright_start = 1'b0;
    bus.ghost_eaten  = 1'b0;
  endtask

  task automatic chk_fsm(input string tag, input int st, input int cnt, input int fr);
    chk({tag, "_state"}, {30'd0, bus.dbg_state}, st);
    chk({tag, "_cnt"}, {23'd0, bus.dbg_frame_cnt}, cnt);
    chk({tag, "_fright"}, {31'd0, bus.frightened}, fr);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 24'h010000 | 24'(i);
    mem[0]   = 24'hFFFFFF;
    mem[675] = 24'h000000;
    mem[674] = 24'hFF0000;

    bus.VS = 1'b1; bus.DrawX = '0; bus.DrawY = '0;
    bus.ghost_x = '0; bus.ghost_y = '0;
    bus.fright_start = 1'b0; bus.ghost_eaten = 1'b0;
    Reset_n = 1'b1;
    #1 Reset_n = 1'b0;
    #1;
    chk("rst_pixel_on", {31'd0, bus.pixel_on}, 0);
    chk("rst_pixel_rgb", {8'd0, bus.pixel_rgb}, 0);
    chk_fsm("rst", 0, 0, 0);
    chk("rst_phase", {31'd0, bus.dbg_flash_phase}, 0);
    tick_clk();
    tick_clk();
    Reset_n = 1'b1;
    tick_clk();

    // Position latch and pipeline timing
    bus.ghost_x = 10'd100; bus.ghost_y = 10'd50;
    frame_tick();
    for (int x = 98; x <= 128; x++) drive_pix(x, 50);
    drain();

    // Transparent bottom-right word, then its red neighbour
    drive_pix(125, 75);
    drive_pix(124, 75);
    drive_pix(125, 76);
    drain();

    // Right-edge placement must not wrap onto column 0
    bus.ghost_x = 10'd1010;
    frame_tick();
    drive_pix(1015, 50);
    chk("wrap_addr5", 32'(model_addr(1015, 50)), 5);
    drive_pix(1023, 60);
    drive_pix(3, 50);
    drive_pix(0, 50);
    drain();

    // Fright timeline
    bus.ghost_x = 10'd100;
    frame_tick();
    pulse(1'b1, 1'b0);
    chk_fsm("fright_enter", 1, 0, 1);
    mdl_mode = 1; mdl_phase = 0;
    drive_pix(100, 50);
    drive_pix(101, 50);
    drain();
    repeat (3) frame_tick();
    chk_fsm("fright_3", 1, 3, 1);
    frame_tick();
    chk_fsm("flash_enter", 2, 0, 1);
    chk("flash_phase0", {31'd0, bus.dbg_flash_phase}, 0);
    mdl_mode = 2; mdl_phase = 0;
    drive_pix(100, 50);
    drain();
    frame_tick();
    chk("flash_phase_t1", {31'd0, bus.dbg_flash_phase}, 0);
    frame_tick();
    chk("flash_phase_t2", {31'd0, bus.dbg_flash_phase}, 1);
    chk_fsm("flash_2", 2, 2, 1);
    mdl_phase = 1;
    drive_pix(100, 50);
    drive_pix(102, 50);
    drain();
    frame_tick();
    chk_fsm("flash_3", 2, 3, 1);
    frame_tick();
    chk_fsm("normal_back", 0, 0, 0);
    mdl_mode = 0; mdl_phase = 0;
    drive_pix(100, 50);
    drain();

    // Restart and priority
    pulse(1'b1, 1'b0);
    repeat (5) frame_tick();
    chk_fsm("restart_pre", 2, 1, 1);
    pulse(1'b1, 1'b0);
    chk_fsm("restart", 1, 0, 1);
    frame_tick();
    chk_fsm("restart_tick", 1, 1, 1);
    pulse(1'b1, 1'b1);
    chk_fsm("eaten_wins", 0, 0, 0);
    pulse(1'b1, 1'b0);
    frame_tick();
    pulse(1'b0, 1'b1);
    chk_fsm("eaten_alone", 0, 0, 0);

    // Asynchronous reset mid-sprite while frightened
    pulse(1'b1, 1'b0);
    bus.DrawX = 10'd101; bus.DrawY = 10'd50;
    tick_clk();
    tick_clk();
    chk("pre_rst_on", {31'd0, bus.pixel_on}, 1);
    chk("pre_rst_rgb", {8'd0, bus.pixel_rgb}, 32'h2121DE);
    #2 Reset_n = 1'b0;
    #1;
    chk("arst_pixel_on", {31'd0, bus.pixel_on}, 0);
    chk("arst_pixel_rgb", {8'd0, bus.pixel_rgb}, 0);
    chk_fsm("arst", 0, 0, 0);
    px = 0; py = 0;
    tick_clk();
    Reset_n = 1'b1;
    tick_clk();
    bus.DrawX = 10'd5; bus.DrawY = 10'd5;
    #1;
    chk("arst_pos_zero", {22'd0, bus.read_address}, 135);
    tick_clk();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
